// File: rtl/demux_rr_mux_if.sv
// Bus bundle for demux_rr_mux: NCH input lanes plus one tagged output stream.
// DEMUX_RR_MUX_PARITY_EN adds the out_par signal to the bundle.
interface demux_rr_mux_if #(
    parameter int unsigned NCH = 4,
    parameter int unsigned DW  = 8
);
    localparam int unsigned SW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [NCH-1:0]    in_valid;
    logic [NCH*DW-1:0] in_data;
    logic [NCH-1:0]    in_ready;
    logic              out_valid;
    logic [DW-1:0]     out_data;
    logic [SW-1:0]     out_sel;
    logic              out_ready;
`ifdef DEMUX_RR_MUX_PARITY_EN
    logic              out_par;

    // Environment side: producers and the downstream consumer
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_sel, out_par
    );

    // Multiplexer side
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_sel, out_par
    );
`else
    // Environment side: producers and the downstream consumer
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_sel
    );

    // Multiplexer side
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_sel
    );
`endif
endinterface

// File: rtl/demux_rr_mux.sv
// Round-robin NCH:1 lane multiplexer with a registered, lane-tagged output.
// Optional feature: define DEMUX_RR_MUX_PARITY_EN to add registered even parity
// over {out_sel, out_data} on out_par.
module demux_rr_mux #(
    parameter int unsigned NCH = 4,
    parameter int unsigned DW  = 8
) (
    input logic            clk,
    input logic            rst,
    demux_rr_mux_if.slave  bus
);
    localparam int unsigned   SW      = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [SW-1:0] PTR_RST = SW'(NCH - 1);

    logic [SW-1:0]  r_ptr;
    logic           r_out_valid;
    logic [DW-1:0]  r_out_data;
    logic [SW-1:0]  r_out_sel;
`ifdef DEMUX_RR_MUX_PARITY_EN
    logic           r_out_par;
`endif

    logic           w_load;
    logic           w_gnt_any;
    logic [SW-1:0]  w_gnt_idx;
    logic [NCH-1:0] w_grant;
    logic [DW-1:0]  w_gnt_data;

    // Output register can take a beat when empty or draining this cycle
    assign w_load = !r_out_valid || bus.out_ready;

    // Rotating-priority search: lanes above the last grant first, then wrap from lane 0
    always_comb begin
        w_gnt_any  = 1'b0;
        w_gnt_idx  = '0;
        w_grant    = '0;
        w_gnt_data = '0;
        if (w_load && !rst) begin
            for (int k = 0; k < NCH; k++) begin
                if (!w_gnt_any && bus.in_valid[k] && (SW'(k) > r_ptr)) begin
                    w_gnt_any = 1'b1;
                    w_gnt_idx = SW'(k);
                end
            end
            for (int k = 0; k < NCH; k++) begin
                if (!w_gnt_any && bus.in_valid[k]) begin
                    w_gnt_any = 1'b1;
                    w_gnt_idx = SW'(k);
                end
            end
        end
        for (int k = 0; k < NCH; k++) begin
            if (w_gnt_any && (w_gnt_idx == SW'(k))) begin
                w_grant[k] = 1'b1;
                w_gnt_data = bus.in_data[k*DW +: DW];
            end
        end
    end

    // Output slice and last-grant pointer; pointer moves only on a grant
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr       <= PTR_RST;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= '0;
`ifdef DEMUX_RR_MUX_PARITY_EN
            r_out_par   <= 1'b0;
`endif
        end else if (w_gnt_any) begin
            r_ptr       <= w_gnt_idx;
            r_out_valid <= 1'b1;
            r_out_data  <= w_gnt_data;
            r_out_sel   <= w_gnt_idx;
`ifdef DEMUX_RR_MUX_PARITY_EN
            r_out_par   <= ^{w_gnt_idx, w_gnt_data};
`endif
        end else if (r_out_valid && bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.in_ready  = w_grant;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_sel   = r_out_sel;
`ifdef DEMUX_RR_MUX_PARITY_EN
    assign bus.out_par   = r_out_par;
`endif

endmodule
